regression_sample_feeder: RTL and testbench



---
 rtl/regression_sample_feeder.sv | 123 ++++++++++++
 tb/tb_regression_sample_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regression_sample_feeder.sv
// regression_sample_feeder: buffers (x,y) pairs and replays them as a primed En burst; SAMPLE_REPLAY_EN keeps the buffer after DONE
module regression_sample_feeder #(
   parameter int DW        = 8,
   parameter int DEPTH     = 16,
   parameter int FLUSH_CYC = 2
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DW-1:0]            x_in,
   input  logic [DW-1:0]            y_in,
   input  logic                     clr,
   input  logic                     start,
   output logic [DW-1:0]            x_out,
   output logic [DW-1:0]            y_out,
   output logic                     en_out,
   output logic                     busy,
   output logic                     full,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     done
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   typedef enum logic [2:0] {IDLE, PRIME, STREAM, FLUSH, DONE} state_t;

   state_t          r_state, w_next;
   logic [CW-1:0]   r_count, w_count;
   logic [AW-1:0]   r_rd_ptr, w_rd_ptr;
   logic [FW-1:0]   r_flush, w_flush;
   logic            r_overflow, w_overflow, r_full, w_wr;
   logic [DW-1:0]   r_xbuf [DEPTH];
   logic [DW-1:0]   r_ybuf [DEPTH];

   // next-state, buffer bookkeeping and pointer/flush counters
   always_comb begin
      w_next     = r_state;
      w_count    = r_count;
      w_rd_ptr   = r_rd_ptr;
      w_flush    = r_flush;
      w_overflow = r_overflow;
      w_wr       = 1'b0;
      case (r_state)
         IDLE: begin
            if (clr) begin
               w_count    = '0;
               w_overflow = 1'b0;
            end else if (wr_en) begin
               if (r_count == CW'(DEPTH)) w_overflow = 1'b1;
               else begin
                  w_wr    = 1'b1;
                  w_count = r_count + CW'(1);
               end
            end
            if (start && w_count != '0) w_next = PRIME;
         end
         PRIME: w_next = STREAM;
         STREAM: begin
            if ({1'b0, r_rd_ptr} == r_count - CW'(1)) begin
               w_next   = FLUSH;
               w_rd_ptr = '0;
               w_flush  = FW'(FLUSH_CYC - 1);
            end else w_rd_ptr = r_rd_ptr + AW'(1);
         end
         FLUSH: begin
            if (r_flush == '0) w_next = DONE;
            else w_flush = r_flush - FW'(1);
         end
         DONE: begin
            w_next = IDLE;
`ifdef SAMPLE_REPLAY_EN
            w_count = r_count;
`else
            w_count = '0;
`endif
         end
         default: w_next = IDLE;
      endcase
   end

   // state, counters and registered outputs derived from the current state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_flush    <= '0;
         r_overflow <= 1'b0;
         r_full     <= 1'b0;
         x_out      <= '0;
         y_out      <= '0;
         en_out     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_count    <= w_count;
         r_rd_ptr   <= w_rd_ptr;
         r_flush    <= w_flush;
         r_overflow <= w_overflow;
         r_full     <= w_count == CW'(DEPTH);
         x_out      <= r_state == STREAM ? r_xbuf[r_rd_ptr] : '0;
         y_out      <= r_state == STREAM ? r_ybuf[r_rd_ptr] : '0;
         en_out     <= r_state == PRIME || r_state == STREAM;
         busy       <= r_state != IDLE;
         done       <= r_state == DONE;
      end
   end

   // sample storage; contents are meaningless until written so no reset
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_xbuf[r_count[AW-1:0]] <= x_in;
         r_ybuf[r_count[AW-1:0]] <= y_in;
      end
   end

   assign count    = r_count;
   assign full     = r_full;
   assign overflow = r_overflow;
endmodule

// File: tb/tb_regression_sample_feeder.sv
// tb_regression_sample_feeder: queue-based model compared every cycle plus directed literal checks
module tb_regression_sample_feeder;
   localparam int FL = 2;

   logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, clr = 1'b0, start = 1'b0;
   logic [7:0] x_in = '0, y_in = '0, x_out, y_out;
   logic       en_out, busy, full, overflow, done;
   logic [4:0] count;

   int errors = 0, checks = 0;
   logic go = 1'b0;
   int cx [20], cy [20];

   typedef struct {logic en; logic [7:0] x; logic [7:0] y; logic busy; logic done; logic clrc;} ent_t;
   ent_t q[$];
   ent_t cur;
   logic [7:0] mx[$], my[$];
   logic movf = 1'b0;

   regression_sample_feeder dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .x_in(x_in), .y_in(y_in), .clr(clr), .start(start),
      .x_out(x_out), .y_out(y_out), .en_out(en_out), .busy(busy), .full(full),
      .overflow(overflow), .count(count), .done(done)
   );

   always #5 clk = ~clk;

   function automatic ent_t mk(logic en, logic [7:0] x, logic [7:0] y, logic b, logic d, logic c);
      ent_t e;
      e.en = en; e.x = x; e.y = y; e.busy = b; e.done = d; e.clrc = c;
      return e;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask

   // behavioural model: a burst is a precomputed list of per-cycle outputs
   initial begin
      cur = mk(0, 0, 0, 0, 0, 0);
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            q.delete(); mx.delete(); my.delete(); movf = 1'b0; cur = mk(0, 0, 0, 0, 0, 0);
         end else if (q.size() > 0) begin
            cur = q.pop_front();
`ifndef SAMPLE_REPLAY_EN
            if (cur.clrc) begin mx.delete(); my.delete(); end
`endif
         end else begin
            cur = mk(0, 0, 0, 0, 0, 0);
            if (clr) begin mx.delete(); my.delete(); movf = 1'b0; end
            else if (wr_en) begin
               if (mx.size() == 16) movf = 1'b1;
               else begin mx.push_back(x_in); my.push_back(y_in); end
            end
            if (start && mx.size() > 0) begin
               q.push_back(mk(1, 0, 0, 1, 0, 0));
               foreach (mx[i]) q.push_back(mk(1, mx[i], my[i], 1, 0, 0));
               repeat (FL) q.push_back(mk(0, 0, 0, 1, 0, 0));
               q.push_back(mk(0, 0, 0, 1, 1, 1));
            end
         end
      end
   end

   // per-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (go) begin
         chk("m_en", en_out, cur.en);
         chk("m_x", x_out, cur.x);
         chk("m_y", y_out, cur.y);
         chk("m_busy", busy, cur.busy);
         chk("m_done", done, cur.done);
         chk("m_count", count, mx.size());
         chk("m_full", full, mx.size() == 16);
         chk("m_ovf", overflow, movf);
      end
   end

   task automatic drive(input logic we, input logic cl, input logic st, input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      wr_en = we; clr = cl; start = st; x_in = x; y_in = y;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic capture(output int nen, output int gap, output logic got);
      int last;
      nen = 0; gap = -1; got = 1'b0; last = -1;
      for (int c = 0; c < 80 && !got; c++) begin
         @(negedge clk);
         if (en_out) begin
            if (nen < 20) begin cx[nen] = x_out; cy[nen] = y_out; end
            nen++;
            last = c;
         end
         if (done) begin got = 1'b1; gap = c - last - 1; end
      end
      chk("done_seen", got, 1);
   endtask

   int nen, gap;
   logic got, seen;

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      go = 1'b1;
      chk("rst_count", count, 0);
      chk("rst_en", en_out, 0);
      chk("rst_busy", busy, 0);
      // three pairs, one burst
      drive(1, 0, 0, 1, 2); drive(1, 0, 0, 2, 4); drive(1, 0, 0, 3, 6);
      drive(0, 0, 1, 0, 0); idle();
      capture(nen, gap, got);
      chk("t1_nen", nen, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_x", cx[i], i);
         chk("t1_y", cy[i], 2 * i);
      end
      chk("t1_gap", gap, 2);
`ifdef SAMPLE_REPLAY_EN
      chk("t1_count_after", count, 3);
`else
      chk("t1_count_after", count, 0);
`endif
      // start on empty buffer
      drive(0, 1, 0, 0, 0); drive(0, 0, 1, 0, 0); idle();
      seen = 1'b0;
      repeat (10) begin @(negedge clk); seen |= busy | en_out | done; end
      chk("t2_quiet", seen, 0);
      // fill, overflow, stream, clear
      drive(0, 1, 0, 0, 0);
      for (int i = 0; i < 16; i++) drive(1, 0, 0, 8'(i + 1), 8'(i + 101));
      drive(1, 0, 0, 8'hAA, 8'hAA); idle();
      @(negedge clk);
      chk("t3_full", full, 1);
      chk("t3_count", count, 16);
      chk("t3_ovf", overflow, 1);
      drive(0, 0, 1, 0, 0); idle();
      capture(nen, gap, got);
      chk("t3_nen", nen, 17);
      chk("t3_last_x", cx[16], 16);
      chk("t3_last_y", cy[16], 116);
      drive(0, 1, 0, 0, 0); idle();
      @(negedge clk);
      chk("t3_clr_count", count, 0);
      chk("t3_clr_full", full, 0);
      chk("t3_clr_ovf", overflow, 0);
      // write and start on the same edge
      drive(1, 0, 0, 5, 5); drive(1, 0, 1, 9, 9); idle();
      capture(nen, gap, got);
      chk("t4_nen", nen, 3);
      chk("t4_x0", cx[0], 0);
      chk("t4_x1", cx[1], 5);
      chk("t4_x2", cx[2], 9);
      chk("t4_y2", cy[2], 9);
      // asynchronous reset mid-stream
      drive(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 8'(i + 20), 8'(i + 30));
      drive(0, 0, 1, 0, 0); idle();
      nen = 0;
      for (int c = 0; c < 20 && nen < 3; c++) begin @(negedge clk); if (en_out) nen++; end
      chk("t5_reached", nen, 3);
      #2 rst = 1'b1;
      #1;
      chk("t5_async_en", en_out, 0);
      chk("t5_async_busy", busy, 0);
      chk("t5_async_count", count, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (12) begin @(negedge clk); seen |= done | busy; end
      chk("t5_no_done", seen, 0);
`ifdef SAMPLE_REPLAY_EN
      // replay the same pairs twice
      drive(0, 1, 0, 0, 0); drive(1, 0, 0, 7, 8); drive(1, 0, 0, 11, 12);
      for (int r = 0; r < 2; r++) begin
         drive(0, 0, 1, 0, 0); idle();
         capture(nen, gap, got);
         chk("t6_nen", nen, 3);
         chk("t6_x1", cx[1], 7);
         chk("t6_y2", cy[2], 12);
         chk("t6_count", count, 2);
      end
`endif
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
